// File: rtl/pc_stack_mod_if.sv
// Control/status bundle between the instruction decoder (master) and the
// program-counter unit (slave).
interface pc_stack_mod_if #(
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 8
);
  localparam int LVL_W = $clog2(STACK_DEPTH) + 1;

  logic [2:0]        rst_pc_in;
  logic [2:0]        int_pc_in;
  logic [7:0]        data_bus;
  logic [2:0]        pc_sel;
  logic [1:0]        offset_sel;
  logic              write_temp_buf;
  logic              push_ret;
  logic              clear_err;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_w_offset;
  logic [LVL_W-1:0]  stack_level;
  logic              stack_full;
  logic              stack_empty;
  logic              stack_overflow;
  logic              stack_underflow;

  modport master (
    output rst_pc_in, int_pc_in, data_bus, pc_sel, offset_sel,
           write_temp_buf, push_ret, clear_err,
    input  pc, pc_w_offset, stack_level, stack_full, stack_empty,
           stack_overflow, stack_underflow
  );

  modport slave (
    input  rst_pc_in, int_pc_in, data_bus, pc_sel, offset_sel,
           write_temp_buf, push_ret, clear_err,
    output pc, pc_w_offset, stack_level, stack_full, stack_empty,
           stack_overflow, stack_underflow
  );
endinterface

// File: rtl/pc_stack_mod.sv
// Parametrised program counter with fetch offset, byte-wise address temp buffer
// and a hardware return-address stack.
module pc_stack_mod #(
  parameter int          ADDR_W      = 16,
  parameter int          OFFSET_W    = 2,
  parameter int          STACK_DEPTH = 8,
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter logic [31:0] RST_BASE    = 32'h0000,
  parameter logic [31:0] INT_BASE    = 32'h0040
) (
  input  logic          clock,
  input  logic          reset,
  pc_stack_mod_if.slave bus
);
  localparam int TEMP_W = ADDR_W - 8;
  localparam int IDX_W  = $clog2(STACK_DEPTH);
  localparam int LVL_W  = IDX_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(STACK_DEPTH);

  typedef enum logic [2:0] {
    SEL_HOLD, SEL_COMMIT, SEL_RST, SEL_INT, SEL_ZERO, SEL_ABS, SEL_REL, SEL_RET
  } pc_sel_e;

  pc_sel_e           sel;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [OFFSET_W-1:0] offset_q, offset_d;
  logic [TEMP_W-1:0] temp_q, temp_d, temp_shift;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

  logic [ADDR_W-1:0] pc_w_offset;
  logic [ADDR_W-1:0] stack_top;
  logic [IDX_W-1:0]  top_idx, wr_idx;
  logic              wr_en, is_empty, is_full, pop_ok, new_ovf, new_unf;

  assign sel         = pc_sel_e'(bus.pc_sel);
  assign pc_w_offset = pc_q + ADDR_W'(offset_q);
  assign is_empty    = (level_q == '0);
  assign is_full     = (level_q == FULL_LVL);
  assign top_idx     = level_q[IDX_W-1:0] - IDX_W'(1);
  assign stack_top   = stack_mem[top_idx];
  assign pop_ok      = (sel == SEL_RET) && !is_empty;

  // Little-endian shift-in: the newest byte lands just below the data_bus byte.
  generate
    if (TEMP_W == 8) begin : g_temp_byte
      assign temp_shift = bus.data_bus;
    end else begin : g_temp_shift
      assign temp_shift = {bus.data_bus, temp_q[TEMP_W-1:8]};
    end
  endgenerate

  always_comb begin
    pc_d     = pc_q;
    level_d  = level_q;
    wr_en    = 1'b0;
    wr_idx   = level_q[IDX_W-1:0];
    new_ovf  = 1'b0;
    new_unf  = 1'b0;
    offset_d = offset_q;
    temp_d   = bus.write_temp_buf ? temp_shift : temp_q;

    unique case (sel)
      SEL_COMMIT: pc_d = pc_w_offset;
      SEL_RST:    pc_d = ADDR_W'(RST_BASE) + ADDR_W'({bus.rst_pc_in, 3'b000});
      SEL_INT:    pc_d = ADDR_W'(INT_BASE) + ADDR_W'({bus.int_pc_in, 3'b000});
      SEL_ZERO:   pc_d = '0;
      SEL_ABS:    pc_d = {bus.data_bus, temp_q};
      SEL_REL:    pc_d = pc_w_offset + {{(ADDR_W-8){bus.data_bus[7]}}, bus.data_bus};
      SEL_RET: begin
        if (pop_ok) pc_d = stack_top;
        else        new_unf = 1'b1;
      end
      default: ;
    endcase

    // A push paired with a successful pop overwrites the slot being popped.
    if (bus.push_ret) begin
      if (pop_ok) begin
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end else if (is_full) begin
        new_ovf = 1'b1;
      end else begin
        wr_en   = 1'b1;
        level_d = level_q + LVL_W'(1);
      end
    end else if (pop_ok) begin
      level_d = level_q - LVL_W'(1);
    end

    if (sel != SEL_HOLD) begin
      offset_d = '0;
    end else begin
      unique case (bus.offset_sel)
        2'd1:    offset_d = offset_q + OFFSET_W'(1);
        2'd2:    offset_d = '0;
        default: offset_d = offset_q;
      endcase
    end

    ovf_d = (ovf_q & ~bus.clear_err) | new_ovf;
    unf_d = (unf_q & ~bus.clear_err) | new_unf;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q     <= ADDR_W'(RESET_PC);
      offset_q <= '0;
      temp_q   <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      offset_q <= offset_d;
      temp_q   <= temp_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Stack storage is not reset; the level counter alone defines valid entries.
  always_ff @(posedge clock) begin
    if (wr_en) stack_mem[wr_idx] <= pc_w_offset;
  end

  assign bus.pc              = pc_q;
  assign bus.pc_w_offset     = pc_w_offset;
  assign bus.stack_level     = level_q;
  assign bus.stack_full      = is_full;
  assign bus.stack_empty     = is_empty;
  assign bus.stack_overflow  = ovf_q;
  assign bus.stack_underflow = unf_q;
endmodule

// File: doc/pc_stack_mod.md
# pc_stack_mod

Parametrised program-counter unit: the successor to the fixed 16-bit PC module, generalised in address width and offset width, and extended with a hardware return-address stack. It sits in the CPU datapath between the instruction decoder (which drives the select lines) and the memory address mux (which consumes `pc` and `pc_w_offset`). It supports calls and returns without spending bus cycles on stack-pointer pushes and pops for the return address.

## Interface
Parameters:
- ADDR_W, 16, PC width; multiple of 8, range 16–32
- OFFSET_W, 2, fetch-offset counter width
- STACK_DEPTH, 8, return-stack entries, power of two, ≥2
- RESET_PC, 0, PC value after reset
- RST_BASE, 'h0000, base of RST vectors
- INT_BASE, 'h0040, base of interrupt vectors

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- rst_pc_in  in  3  RST vector index
- int_pc_in  in  3  interrupt vector index
- data_bus  in  8  byte from memory
- pc_sel  in  3  PC next-value select (encoding below)
- offset_sel  in  2  0 hold, 1 increment, 2 zero, 3 hold
- write_temp_buf  in  1  shift data_bus into the address temp buffer
- push_ret  in  1  push current pc_w_offset onto the return stack
- clear_err  in  1  clear the sticky stack error flags
- pc  out  ADDR_W  registered program counter
- pc_w_offset  out  ADDR_W  pc + zero-extended offset, mod 2^ADDR_W (combinational from registers only)
- stack_level  out  $clog2(STACK_DEPTH)+1  entries in use, 0..STACK_DEPTH
- stack_full  out  1  stack_level == STACK_DEPTH
- stack_empty  out  1  stack_level == 0
- stack_overflow  out  1  sticky: push attempted while full
- stack_underflow  out  1  sticky: pop attempted while empty

## Operation
- Reset values: pc = RESET_PC; offset = 0; temp = 0; stack_level = 0; both error flags 0. Stack RAM contents are don't-care.
- Temp buffer: ADDR_W-8 bits, little-endian. When write_temp_buf = 1: temp <= {data_bus, temp[ADDR_W-9:8]}. For ADDR_W = 16 this is simply temp <= data_bus.
- pc_sel encoding:
  - 0: hold.
  - 1: pc <= pc_w_offset (commit the fetch offset).
  - 2: pc <= RST_BASE + (rst_pc_in << 3).
  - 3: pc <= INT_BASE + (int_pc_in << 3).
  - 4: pc <= 0.
  - 5: pc <= {data_bus, temp}.
  - 6: pc <= pc_w_offset + sign_extend(data_bus).
  - 7: return; pc <= stack top, pop.
- All PC arithmetic is mod 2^ADDR_W.
- Offset: when pc_sel ≠ 0, offset <= 0 and offset_sel is ignored. Otherwise offset follows offset_sel. Increment wraps mod 2^OFFSET_W (3 → 0 with the default).
- push_ret: writes the pre-edge pc_w_offset to entry stack_level and increments the level. Independent of pc_sel, so a call is push_ret = 1 together with pc_sel = 5.
- Push while full: push dropped, stack_overflow <= 1, pc_sel still executes.
- Pop (pc_sel = 7) while empty: pc holds, stack_underflow <= 1, offset still cleared.
- Simultaneous push_ret and pop with level ≥ 1: pc <= old top, the top entry is replaced by pc_w_offset, level unchanged.
- Simultaneous push_ret and pop with level 0: underflow is flagged, the push proceeds, level becomes 1.
- clear_err clears both error flags. If a new error occurs in the same cycle, set wins.

## Timing
- Every register updates on the rising clock edge. Inputs are sampled at that edge and results are visible after it: one-cycle latency.
- pc_w_offset, stack_full and stack_empty are derived combinationally from registers only, with no input-to-output path.
- A 16-bit absolute load takes 2 cycles: write_temp_buf, then pc_sel = 5. For ADDR_W = 24/32 it takes ADDR_W/8 cycles.
- Reset asserted mid-sequence (during a load or at a non-zero level) takes effect immediately and asynchronously. The first edge after reset deasserts behaves as a normal cycle.

## Test plan
- Reset, then 'hCD via write_temp_buf, then pc_sel = 5 with data_bus = 'hAB → pc = 'hABCD. Assert reset low → pc = 0 with no clock edge.
- Vectors: rst_pc_in 0..7 → pc = 'h00..'h38 in steps of 8. int_pc_in 0..4 → pc = 'h40..'h60.
- Relative from pc = 'h4567: data_bus 'h03 → 'h456A; then 'hFF → 'h4569. From pc = 'h0001, data_bus 'hFE → 'hFFFF. From pc = 'h0080, data_bus 'h80 → 'h0000.
- Offset at pc = 'hFFFE: two increments → pc_w_offset = 'h0000. Then pc_sel = 1 → pc = 'h0000, offset = 0. Offset 3 plus one increment → offset wraps to 0.
- Stack:
  - Call at pc = 'h0100 with offset 2 (push_ret + load 'h2000) → level 1, pc = 'h2000. Return → pc = 'h0102, level 0.
  - Fill to 8, push again → stack_overflow = 1, level stays 8.
  - Drain to empty, then pop → stack_underflow = 1, pc unchanged.
  - clear_err → both flags 0.
- Instance with ADDR_W = 24: three-byte load 'h12, 'h34, then pc_sel = 5 with data_bus 'h56 → pc = 'h563412. Relative 'hFF from 'h000000 → 'hFFFFFF.
